// File: rtl/axil_bus_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port between NM requesters.
// A whole read (AR+R) or write (AW+W+B) transaction is owned by one master at a time.
module axil_bus_arbiter #(
    parameter int NM = 2,
    parameter int AW = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NM-1:0]     m_arvalid,
    output logic [NM-1:0]     m_arready,
    input  logic [AW*NM-1:0]  m_araddr,
    input  logic [3*NM-1:0]   m_arprot,
    output logic [NM-1:0]     m_rvalid,
    input  logic [NM-1:0]     m_rready,
    output logic [31:0]       m_rdata,
    input  logic [NM-1:0]     m_awvalid,
    output logic [NM-1:0]     m_awready,
    input  logic [AW*NM-1:0]  m_awaddr,
    input  logic [3*NM-1:0]   m_awprot,
    input  logic [NM-1:0]     m_wvalid,
    output logic [NM-1:0]     m_wready,
    input  logic [32*NM-1:0]  m_wdata,
    input  logic [4*NM-1:0]   m_wstrb,
    output logic [NM-1:0]     m_bvalid,
    input  logic [NM-1:0]     m_bready,
    output logic              s_arvalid,
    input  logic              s_arready,
    output logic [AW-1:0]     s_araddr,
    output logic [2:0]        s_arprot,
    input  logic              s_rvalid,
    input  logic [31:0]       s_rdata,
    output logic              s_rready,
    output logic              s_awvalid,
    input  logic              s_awready,
    output logic [AW-1:0]     s_awaddr,
    output logic [2:0]        s_awprot,
    output logic              s_wvalid,
    input  logic              s_wready,
    output logic [31:0]       s_wdata,
    output logic [3:0]        s_wstrb,
    input  logic              s_bvalid,
    output logic              s_bready,
    output logic [NM-1:0]     grant,
    output logic              busy
);

    localparam int IW = (NM > 1) ? $clog2(NM) : 1;
    localparam int unsigned NMU = NM;

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WRITE, WRESP} state_t;

    state_t          state, state_d;
    logic [IW-1:0]   g, g_d, last, last_d, pick;
    logic [NM-1:0]   grant_d, req;
    logic            aw_done, aw_done_d, w_done, w_done_d;
    logic            found, aw_v, w_v, aw_hs, w_hs;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            g       <= '0;
            last    <= IW'(NM - 1);
            grant   <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_d;
            g       <= g_d;
            last    <= last_d;
            grant   <= grant_d;
            aw_done <= aw_done_d;
            w_done  <= w_done_d;
        end
    end

    // First requester after the previous owner, wrapping modulo NM.
    always_comb begin
        req   = m_arvalid | m_awvalid;
        pick  = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= NMU; k++) begin
            int unsigned cand;
            cand = (32'(last) + k) % NMU;
            if (!found && req[IW'(cand)]) begin
                pick  = IW'(cand);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state;
        g_d       = g;
        last_d    = last;
        grant_d   = grant;
        aw_done_d = aw_done;
        w_done_d  = w_done;
        m_arready = '0;
        m_rvalid  = '0;
        m_rdata   = '0;
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        s_arvalid = 1'b0;
        s_araddr  = '0;
        s_arprot  = '0;
        s_rready  = 1'b0;
        s_awvalid = 1'b0;
        s_awaddr  = '0;
        s_awprot  = '0;
        s_wvalid  = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_bready  = 1'b0;
        aw_v      = 1'b0;
        w_v       = 1'b0;
        aw_hs     = 1'b0;
        w_hs      = 1'b0;
        busy      = (state != IDLE);

        case (state)
            IDLE: begin
                if (found) begin
                    g_d           = pick;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    state_d       = m_arvalid[pick] ? RADDR : WRITE;
                end
            end
            RADDR: begin
                s_arvalid    = m_arvalid[g];
                s_araddr     = m_araddr[AW*g +: AW];
                s_arprot     = m_arprot[3*g +: 3];
                m_arready[g] = s_arready;
                if (m_arvalid[g] && s_arready)
                    state_d = RDATA;
            end
            RDATA: begin
                m_rvalid[g] = s_rvalid;
                m_rdata     = s_rdata;
                s_rready    = m_rready[g];
                if (s_rvalid && m_rready[g]) begin
                    state_d = IDLE;
                    last_d  = g;
                    grant_d = '0;
                end
            end
            WRITE: begin
                // AW and W complete independently; each is masked once it has handshaked.
                aw_v         = m_awvalid[g] & ~aw_done;
                w_v          = m_wvalid[g] & ~w_done;
                s_awvalid    = aw_v;
                s_awaddr     = m_awaddr[AW*g +: AW];
                s_awprot     = m_awprot[3*g +: 3];
                m_awready[g] = s_awready & ~aw_done;
                s_wvalid     = w_v;
                s_wdata      = m_wdata[32*g +: 32];
                s_wstrb      = m_wstrb[4*g +: 4];
                m_wready[g]  = s_wready & ~w_done;
                aw_hs        = aw_v & s_awready;
                w_hs         = w_v & s_wready;
                aw_done_d    = aw_done | aw_hs;
                w_done_d     = w_done | w_hs;
                if (aw_done_d && w_done_d)
                    state_d = WRESP;
            end
            WRESP: begin
                m_bvalid[g] = s_bvalid;
                s_bready    = m_bready[g];
                if (s_bvalid && m_bready[g]) begin
                    state_d   = IDLE;
                    last_d    = g;
                    grant_d   = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axil_bus_arbiter.sv
// Directed bench for axil_bus_arbiter (NM=2): reset, read, round-robin, write, backpressure.
module tb_axil_bus_arbiter;

    localparam int NM = 2;
    localparam int AW = 32;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NM-1:0]     m_arvalid, m_arready, m_rvalid, m_rready;
    logic [AW*NM-1:0]  m_araddr, m_awaddr;
    logic [3*NM-1:0]   m_arprot, m_awprot;
    logic [31:0]       m_rdata;
    logic [NM-1:0]     m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [32*NM-1:0]  m_wdata;
    logic [4*NM-1:0]   m_wstrb;
    logic              s_arvalid, s_arready, s_rvalid, s_rready;
    logic [AW-1:0]     s_araddr, s_awaddr;
    logic [2:0]        s_arprot, s_awprot;
    logic [31:0]       s_rdata, s_wdata;
    logic              s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [3:0]        s_wstrb;
    logic [NM-1:0]     grant;
    logic              busy;

    int total = 0;
    int bad   = 0;
    int aw_cnt = 0;
    int w_cnt  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (s_awvalid && s_awready) aw_cnt++;
        if (s_wvalid && s_wready)   w_cnt++;
    end

    axil_bus_arbiter #(.NM(NM), .AW(AW)) dut (
        .clk(clk), .rstn(rstn),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rready(s_rready),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .grant(grant), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_arvalid = '0; m_araddr = '0; m_arprot = '0; m_rready = '0;
        m_awvalid = '0; m_awaddr = '0; m_awprot = '0;
        m_wvalid = '0; m_wdata = '0; m_wstrb = '0; m_bready = '0;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        logic [13:0] obs;
        clear_inputs();
        rstn = 1'b0;
        tick();
        tick();
        obs = {grant, busy, s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready,
               m_arready, m_rvalid, m_bvalid};
        total++;
        if (obs !== 14'h0) begin
            bad++;
            $display("FAIL reset_ctrl got=%h exp=%h", obs, 14'h0);
        end
        total++;
        if ({s_araddr, s_awaddr, s_wdata, s_wstrb} !== '0) begin
            bad++;
            $display("FAIL reset_data got=%h exp=0", {s_araddr, s_awaddr, s_wdata, s_wstrb});
        end
        rstn = 1'b1;
    endtask

    task automatic test_read();
        m_arvalid = 2'b01; m_araddr[31:0] = 32'h0000_0100; m_arprot[2:0] = 3'b010;
        s_arready = 1'b1;
        #1;
        total++;
        if ({busy, s_arvalid} !== 2'b00) begin
            bad++;
            $display("FAIL read_cycle0 got=%b exp=00", {busy, s_arvalid});
        end
        tick();
        total++;
        if ({s_arvalid, s_araddr, s_arprot, m_arready, grant, busy} !==
            {1'b1, 32'h0000_0100, 3'b010, 2'b01, 2'b01, 1'b1}) begin
            bad++;
            $display("FAIL read_addr got=%h exp=%h", {s_arvalid, s_araddr, s_arprot, m_arready, grant, busy},
                     {1'b1, 32'h0000_0100, 3'b010, 2'b01, 2'b01, 1'b1});
        end
        tick();
        m_arvalid = '0; s_arready = 1'b0;
        s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF; m_rready = 2'b01;
        #1;
        total++;
        if ({m_rvalid, m_rdata, s_rready, s_arvalid} !== {2'b01, 32'hDEAD_BEEF, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL read_data got=%h exp=%h", {m_rvalid, m_rdata, s_rready, s_arvalid},
                     {2'b01, 32'hDEAD_BEEF, 1'b1, 1'b0});
        end
        tick();
        clear_inputs();
        #1;
        total++;
        if ({grant, busy, m_rvalid} !== 5'b0) begin
            bad++;
            $display("FAIL read_done got=%b exp=00000", {grant, busy, m_rvalid});
        end
    endtask

    task automatic test_round_robin();
        logic [NM-1:0] exp_g;
        logic [31:0]   exp_a;
        do_reset();
        m_arvalid = 2'b11;
        m_araddr  = {32'h0000_1111, 32'h0000_0000};
        s_arready = 1'b1; s_rvalid = 1'b1; m_rready = 2'b11;
        for (int t = 0; t < 4; t++) begin
            exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
            exp_a = (t % 2 == 0) ? 32'h0 : 32'h0000_1111;
            tick();
            total++;
            if ({grant, s_araddr} !== {exp_g, exp_a}) begin
                bad++;
                $display("FAIL rr_grant%0d got=%h exp=%h", t, {grant, s_araddr}, {exp_g, exp_a});
            end
            tick();
            tick();
            total++;
            if ({busy, grant} !== 3'b000) begin
                bad++;
                $display("FAIL rr_idle_gap%0d got=%b exp=000", t, {busy, grant});
            end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_write();
        aw_cnt = 0; w_cnt = 0;
        m_awvalid = 2'b10; m_wvalid = 2'b10; m_bready = 2'b10;
        m_awaddr[63:32] = 32'h0000_0020; m_awprot[5:3] = 3'b001;
        m_wdata[63:32] = 32'hA5A5_A5A5; m_wstrb[7:4] = 4'hF;
        s_wready = 1'b1;
        tick();
        total++;
        if ({grant, s_awvalid, s_wvalid, s_awaddr, s_awprot, s_wdata, s_wstrb, m_wready, m_awready} !==
            {2'b10, 1'b1, 1'b1, 32'h20, 3'b001, 32'hA5A5_A5A5, 4'hF, 2'b10, 2'b00}) begin
            bad++;
            $display("FAIL wr_fwd got=%h exp=%h",
                     {grant, s_awvalid, s_wvalid, s_awaddr, s_awprot, s_wdata, s_wstrb, m_wready, m_awready},
                     {2'b10, 1'b1, 1'b1, 32'h20, 3'b001, 32'hA5A5_A5A5, 4'hF, 2'b10, 2'b00});
        end
        tick();
        total++;
        if ({s_wvalid, m_wready, s_awvalid, busy} !== {1'b0, 2'b00, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL wr_wmask got=%b exp=%b", {s_wvalid, m_wready, s_awvalid, busy}, 5'b00011);
        end
        tick();
        s_awready = 1'b1;
        #1;
        total++;
        if ({m_awready, s_awvalid} !== 3'b101) begin
            bad++;
            $display("FAIL wr_awready got=%b exp=101", {m_awready, s_awvalid});
        end
        tick();
        m_awvalid = '0; m_wvalid = '0; s_awready = 1'b0; s_wready = 1'b0;
        #1;
        total++;
        if ({s_awvalid, s_bready, m_bvalid, busy} !== {1'b0, 1'b1, 2'b00, 1'b1}) begin
            bad++;
            $display("FAIL wr_wresp got=%b exp=01001", {s_awvalid, s_bready, m_bvalid, busy});
        end
        s_bvalid = 1'b1;
        #1;
        total++;
        if (m_bvalid !== 2'b10) begin
            bad++;
            $display("FAIL wr_bvalid got=%b exp=10", m_bvalid);
        end
        tick();
        clear_inputs();
        #1;
        total++;
        if ({busy, grant, aw_cnt[3:0], w_cnt[3:0]} !== {1'b0, 2'b00, 4'd1, 4'd1}) begin
            bad++;
            $display("FAIL wr_done got=%h exp=%h", {busy, grant, aw_cnt[3:0], w_cnt[3:0]}, {1'b0, 2'b00, 4'd1, 4'd1});
        end
    endtask

    task automatic test_read_then_write();
        m_arvalid = 2'b01; m_awvalid = 2'b01; m_wvalid = 2'b01;
        m_araddr[31:0] = 32'h40; m_awaddr[31:0] = 32'h44; m_wdata[31:0] = 32'h1234_5678; m_wstrb[3:0] = 4'h3;
        s_arready = 1'b1; s_rvalid = 1'b1; m_rready = 2'b01;
        s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1; m_bready = 2'b01;
        tick();
        total++;
        if ({grant, s_arvalid, s_awvalid, s_wvalid} !== 5'b01100) begin
            bad++;
            $display("FAIL rw_read_first got=%b exp=01100", {grant, s_arvalid, s_awvalid, s_wvalid});
        end
        tick();
        m_arvalid = '0;
        #1;
        total++;
        if (m_rvalid !== 2'b01) begin
            bad++;
            $display("FAIL rw_rdata got=%b exp=01", m_rvalid);
        end
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL rw_idle got=%b exp=0", busy);
        end
        tick();
        total++;
        if ({grant, s_awvalid, s_wvalid, s_awaddr, s_wdata, s_wstrb} !==
            {2'b01, 1'b1, 1'b1, 32'h44, 32'h1234_5678, 4'h3}) begin
            bad++;
            $display("FAIL rw_write got=%h exp=%h", {grant, s_awvalid, s_wvalid, s_awaddr, s_wdata, s_wstrb},
                     {2'b01, 1'b1, 1'b1, 32'h44, 32'h1234_5678, 4'h3});
        end
        tick();
        m_awvalid = '0; m_wvalid = '0;
        #1;
        total++;
        if ({m_bvalid, s_bready, s_awvalid, s_wvalid} !== 5'b01100) begin
            bad++;
            $display("FAIL rw_same_cycle_wresp got=%b exp=01100", {m_bvalid, s_bready, s_awvalid, s_wvalid});
        end
        tick();
        clear_inputs();
        #1;
        total++;
        if ({busy, grant} !== 3'b000) begin
            bad++;
            $display("FAIL rw_done got=%b exp=000", {busy, grant});
        end
    endtask

    task automatic test_rready_backpressure();
        m_arvalid = 2'b01; s_arready = 1'b1;
        tick();
        tick();
        m_arvalid = '0; s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hCAFE_F00D; m_rready = 2'b00;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if ({s_rready, busy, m_rvalid, m_rdata} !== {1'b0, 1'b1, 2'b01, 32'hCAFE_F00D}) begin
                bad++;
                $display("FAIL bp_hold%0d got=%h exp=%h", c, {s_rready, busy, m_rvalid, m_rdata},
                         {1'b0, 1'b1, 2'b01, 32'hCAFE_F00D});
            end
            tick();
        end
        m_rready = 2'b01;
        #1;
        total++;
        if (s_rready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release got=%b exp=1", s_rready);
        end
        tick();
        clear_inputs();
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL bp_done got=%b exp=0", busy);
        end
    endtask

    task automatic test_reset_mid_wresp();
        m_awvalid = 2'b10; m_wvalid = 2'b10; m_bready = 2'b10;
        s_awready = 1'b1; s_wready = 1'b1;
        tick();
        tick();
        m_awvalid = '0; m_wvalid = '0;
        #1;
        total++;
        if ({grant, busy, s_bready} !== 4'b1011) begin
            bad++;
            $display("FAIL mid_in_wresp got=%b exp=1011", {grant, busy, s_bready});
        end
        #2;
        rstn = 1'b0;
        #1;
        total++;
        if ({grant, busy, s_bready, s_arvalid, s_awvalid, s_wvalid, m_bvalid} !== 9'b0) begin
            bad++;
            $display("FAIL mid_reset got=%b exp=0", {grant, busy, s_bready, s_arvalid, s_awvalid, s_wvalid, m_bvalid});
        end
        clear_inputs();
        tick();
        rstn = 1'b1;
        m_arvalid = 2'b11; s_arready = 1'b1; s_rvalid = 1'b1; m_rready = 2'b11;
        tick();
        total++;
        if (grant !== 2'b01) begin
            bad++;
            $display("FAIL mid_first_after got=%b exp=01", grant);
        end
        clear_inputs();
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        clear_inputs();
        test_reset();
        test_read();
        test_round_robin();
        test_write();
        test_read_then_write();
        test_rready_backpressure();
        test_reset_mid_wresp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
